// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port DataMemory: CPU load/store path has priority,
// DMA gets a slot after MAX_CPU_RUN consecutive contended CPU grants. One access per 2 cycles.
module data_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_CPU_RUN + 1);

  typedef enum logic {IDLE, ACCESS} stateT;

  stateT           state, nextState;
  logic [CW-1:0]   runCnt, runCntNext;
  logic            grantCpu, grantDma;
  logic            winnerDma;
  logic            memWe, memRe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic            cpuRvalid, dmaRvalid;
  logic [DATA_WIDTH-1:0] cpuRdata, dmaRdata;
  logic            selWe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      runCnt <= '0;
    end else begin
      state  <= nextState;
      runCnt <= runCntNext;
    end
  end

  // DMA wins only when the CPU is idle or has used up its run of contended grants
  always_comb begin
    nextState  = state;
    grantCpu   = 1'b0;
    grantDma   = 1'b0;
    runCntNext = runCnt;
    case (state)
      IDLE: begin
        if (!dma_req) runCntNext = '0;
        if (dma_req && (!cpu_req || runCnt == CW'(MAX_CPU_RUN))) begin
          grantDma   = 1'b1;
          runCntNext = '0;
          nextState  = ACCESS;
        end else if (cpu_req) begin
          grantCpu  = 1'b1;
          nextState = ACCESS;
          if (dma_req && runCnt != CW'(MAX_CPU_RUN)) runCntNext = runCnt + CW'(1);
        end
      end
      ACCESS:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    selWe    = grantDma ? dma_we    : cpu_we;
    selAddr  = grantDma ? dma_addr  : cpu_addr;
    selWdata = grantDma ? dma_wdata : cpu_wdata;
  end

  // Command is registered on the arbitration edge and withdrawn at the closing edge of ACCESS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memWe     <= 1'b0;
      memRe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      winnerDma <= 1'b0;
      cpuRvalid <= 1'b0;
      dmaRvalid <= 1'b0;
      cpuRdata  <= '0;
      dmaRdata  <= '0;
    end else begin
      cpuRvalid <= (state == ACCESS) && memRe && !winnerDma;
      dmaRvalid <= (state == ACCESS) && memRe && winnerDma;
      if (state == ACCESS && memRe) begin
        if (winnerDma) dmaRdata <= mem_rdata;
        else           cpuRdata <= mem_rdata;
      end
      if (grantCpu || grantDma) begin
        memWe     <= selWe;
        memRe     <= !selWe;
        memAddr   <= selAddr & ~ADDR_WIDTH'(3);
        memWdata  <= selWdata;
        winnerDma <= grantDma;
      end else begin
        memWe <= 1'b0;
        memRe <= 1'b0;
      end
    end
  end

  assign cpu_gnt    = (state == ACCESS) && !winnerDma;
  assign dma_gnt    = (state == ACCESS) && winnerDma;
  assign cpu_rvalid = cpuRvalid;
  assign dma_rvalid = dmaRvalid;
  assign cpu_rdata  = cpuRdata;
  assign dma_rdata  = dmaRdata;
  assign mem_we     = memWe;
  assign mem_re     = memRe;
  assign mem_addr   = memAddr;
  assign mem_wdata  = memWdata;
  // Gated by reset so every output reads 0 while reset is held
  assign cpu_stall  = reset && cpu_req && !(cpu_gnt && cpu_we) && !cpu_rvalid;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: behavioural RAM, read-data scoreboard queues,
// and an expected grant-order queue for the fairness scenario.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] cpuExpQ[$];
  logic [31:0] dmaExpQ[$];
  logic        grantQ[$];
  logic [31:0] modelMem [int];

  logic [31:0]  ramArr [0:255];
  logic [255:0] written = '0;
  logic [134:0] allOut;

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_CPU_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign allOut = {cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, mem_we, mem_re,
                   cpu_rdata, dma_rdata, mem_addr, mem_wdata};

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return 32'hA5A50000 | {16'h0000, a[15:0] & 16'hFFFC};
  endfunction

  function automatic logic [31:0] expectedAt(input logic [31:0] a);
    int key = int'(a & ~32'd3);
    if (modelMem.exists(key)) return modelMem[key];
    return initVal(a);
  endfunction

  // Behavioural single-port RAM: combinational read while mem_re, write at the clock edge
  always @(posedge clk) begin
    if (mem_we) begin
      ramArr[mem_addr[9:2]]  <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_re) mem_rdata = written[mem_addr[9:2]] ? ramArr[mem_addr[9:2]] : initVal(mem_addr);
  end

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWdata;
    dma_req = dReq; dma_we = dWe; dma_addr = dAddr; dma_wdata = dWdata;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    testsRun++;
    if (allOut !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", allOut);
    end
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: we=%b re=%b cg=%b dg=%b, want 0", mem_we, mem_re, cpu_gnt, dma_gnt);
    end
  endtask

  task automatic test_write_read;
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    @(negedge clk);
    testsRun++;
    if ({cpu_gnt, mem_we, mem_re, cpu_stall} !== 4'b1100 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL cpu_write_issue: gnt/we/re/stall=%b%b%b%b addr=%h data=%h, want 1100 10 deadbeef",
               cpu_gnt, mem_we, mem_re, cpu_stall, mem_addr, mem_wdata);
    end
    modelMem[32'h10] = 32'hDEADBEEF;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    cpuExpQ.push_back(expectedAt(32'h10));
    @(negedge clk);
    testsRun++;
    if ({cpu_gnt, mem_re, mem_we, cpu_stall} !== 4'b1101) begin
      testsFailed++;
      $display("[TB] FAIL cpu_read_issue: gnt/re/we/stall=%b%b%b%b, want 1101", cpu_gnt, mem_re, mem_we, cpu_stall);
    end
    @(negedge clk);
    testsRun++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== cpuExpQ.pop_front()) begin
      testsFailed++;
      $display("[TB] FAIL cpu_read_data: rvalid=%b rdata=%h, want 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midrun;
    logic busy;
    @(negedge clk);
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    testsRun++;
    if (allOut !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_midrun_outputs: got %h, want 0", allOut);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      busy |= cpu_gnt | dma_gnt | mem_we | mem_re | cpu_rvalid;
    end
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_midrun_idle: activity=%b, want 0", busy);
    end
  endtask

  task automatic test_arbitration;
    applyStimulus(1, 1, 32'h30, 32'h33330000, 1, 1, 32'h34, 32'h44440000);
    @(negedge clk);
    testsRun++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL arb_first: cg/dg=%b%b, want 10", cpu_gnt, dma_gnt);
    end
    modelMem[32'h30] = 32'h33330000;
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h34, 32'h44440000);
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if ({cpu_gnt, dma_gnt} !== 2'b01 || mem_addr !== 32'h34 || mem_we !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL arb_second: cg/dg=%b%b addr=%h we=%b, want 01 34 1", cpu_gnt, dma_gnt, mem_addr, mem_we);
    end
    modelMem[32'h34] = 32'h44440000;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_fairness;
    logic exp;
    logic both = 1'b0;
    for (int n = 0; n < 10; n++) grantQ.push_back((n % 5) == 4);
    applyStimulus(1, 1, 32'h40, 32'h11111111, 1, 1, 32'h44, 32'h22222222);
    for (int cyc = 0; cyc < 40 && grantQ.size() > 0; cyc++) begin
      @(negedge clk);
      both |= cpu_gnt & dma_gnt;
      if (cpu_gnt || dma_gnt) begin
        exp = grantQ.pop_front();
        testsRun++;
        if (dma_gnt !== exp) begin
          testsFailed++;
          $display("[TB] FAIL fair_order: grant %0d dma_gnt=%b, want %b", 9 - grantQ.size(), dma_gnt, exp);
        end
        if (dma_gnt) modelMem[32'h44] = 32'h22222222;
        else         modelMem[32'h40] = 32'h11111111;
      end
    end
    testsRun++;
    if (grantQ.size() != 0 || both) begin
      testsFailed++;
      $display("[TB] FAIL fair_progress: pending=%0d both=%b, want 0 0", grantQ.size(), both);
      grantQ.delete();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    applyStimulus(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
    cpuExpQ.push_back(expectedAt(32'h40));
    dmaExpQ.push_back(expectedAt(32'h44));
    @(negedge clk);
    testsRun++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL b2b_cpu_gnt: cg/dg=%b%b, want 10", cpu_gnt, dma_gnt);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h44, 0);
    @(negedge clk);
    testsRun++;
    if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== cpuExpQ.pop_front()) begin
      testsFailed++;
      $display("[TB] FAIL b2b_cpu_read: crv=%b drv=%b rdata=%h, want 1 0 11111111", cpu_rvalid, dma_rvalid, cpu_rdata);
    end
    @(negedge clk);
    testsRun++;
    if ({cpu_gnt, dma_gnt, mem_re} !== 3'b011) begin
      testsFailed++;
      $display("[TB] FAIL b2b_dma_gnt: cg/dg/re=%b%b%b, want 011", cpu_gnt, dma_gnt, mem_re);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    testsRun++;
    if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== dmaExpQ.pop_front()) begin
      testsFailed++;
      $display("[TB] FAIL b2b_dma_read: drv=%b crv=%b rdata=%h, want 1 0 22222222", dma_rvalid, cpu_rvalid, dma_rdata);
    end
  endtask

  task automatic test_reset_write;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
    @(negedge clk);
    testsRun++;
    if ({dma_gnt, mem_we} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL dma_write_issue: dg/we=%b%b, want 11", dma_gnt, mem_we);
    end
    #2 reset = 1'b0;
    #1;
    testsRun++;
    if ({dma_gnt, mem_we} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_drops_we: dg/we=%b%b, want 00", dma_gnt, mem_we);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0);
    cpuExpQ.push_back(expectedAt(32'h20));
    repeat (2) @(negedge clk);
    testsRun++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== cpuExpQ.pop_front()) begin
      testsFailed++;
      $display("[TB] FAIL reset_write_lost: rvalid=%b rdata=%h, want 1 %h", cpu_rvalid, cpu_rdata, initVal(32'h20));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    applyStimulus(1, 0, 32'h13, 0, 0, 0, 0, 0);
    cpuExpQ.push_back(expectedAt(32'h10));
    #1;
    testsRun++;
    if (cpu_stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stall_on_req: stall=%b, want 1", cpu_stall);
    end
    @(negedge clk);
    testsRun++;
    if (mem_addr !== 32'h10 || cpu_stall !== 1'b1 || mem_re !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL misaligned_addr: addr=%h stall=%b re=%b, want 10 1 1", mem_addr, cpu_stall, mem_re);
    end
    @(negedge clk);
    testsRun++;
    if (cpu_rvalid !== 1'b1 || cpu_stall !== 1'b0 || cpu_rdata !== cpuExpQ.pop_front()) begin
      testsFailed++;
      $display("[TB] FAIL misaligned_read: rvalid=%b stall=%b rdata=%h, want 1 0 deadbeef", cpu_rvalid, cpu_stall, cpu_rdata);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_midrun();
    test_arbitration();
    test_fairness();
    test_back_to_back();
    test_reset_write();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
